// File: rtl/ceespu_imem_pipe.sv
// ceespu_imem_pipe: instruction memory with a configurable-latency read pipeline,
// synchronous flush, boot-load write port and fault/misalign flags.
module ceespu_imem_pipe #(
    parameter int    ADDR_WIDTH  = 16,
    parameter int    DEPTH_LOG2  = 14,
    parameter int    LATENCY     = 1,
    parameter int    WORD_OFFSET = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic [ADDR_WIDTH-1:0] I_imemAddress,
    input  logic                  I_imemEnable,
    input  logic                  I_imemReset,
    output logic [31:0]           O_imemData,
    output logic                  O_imemValid,
    output logic                  O_imemFault,
    output logic                  O_imemMisalign,
    input  logic                  I_loadWe,
    input  logic [DEPTH_LOG2-1:0] I_loadAddr,
    input  logic [31:0]           I_loadData
);
    localparam int IW    = ADDR_WIDTH - 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_data [LATENCY];
    logic [LATENCY-1:0]    r_valid;
    logic [LATENCY-1:0]    r_fault;
    logic [LATENCY-1:0]    r_mis;
    logic [IW-1:0]         w_idx_full;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_fault;

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("ceespu_imem_pipe: LATENCY must be 1..4");
        end
        // Indices past the array wrap but are flagged so the core can trap on them.
        if (DEPTH_LOG2 < IW) begin : g_wrap
            assign w_idx   = w_idx_full[DEPTH_LOG2-1:0];
            assign w_fault = |w_idx_full[IW-1:DEPTH_LOG2];
        end else begin : g_nowrap
            assign w_idx   = DEPTH_LOG2'(w_idx_full);
            assign w_fault = 1'b0;
        end
    endgenerate

    assign w_idx_full = IW'(I_imemAddress[ADDR_WIDTH-1:2]) + IW'(WORD_OFFSET);

    always_ff @(posedge I_clk) begin
        if (!I_rst && I_loadWe)
            r_mem[I_loadAddr] <= I_loadData;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst || I_imemReset) begin
            r_data  <= '{default: '0};
            r_valid <= '0;
            r_fault <= '0;
            r_mis   <= '0;
        end else if (I_imemEnable) begin
            r_data[0]  <= r_mem[w_idx];
            r_valid[0] <= 1'b1;
            r_fault[0] <= w_fault;
            r_mis[0]   <= |I_imemAddress[1:0];
            for (int k = 1; k < LATENCY; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
                r_fault[k] <= r_fault[k-1];
                r_mis[k]   <= r_mis[k-1];
            end
        end
    end

    assign O_imemData     = r_data[LATENCY-1];
    assign O_imemValid    = r_valid[LATENCY-1];
    assign O_imemFault    = r_fault[LATENCY-1];
    assign O_imemMisalign = r_mis[LATENCY-1];
endmodule

// File: tb/tb_ceespu_imem_pipe.sv
// tb_ceespu_imem_pipe: directed checks of a LATENCY=1 full-depth instance and a
// LATENCY=3, 16-word instance sharing one stimulus stream.
module tb_ceespu_imem_pipe;
    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic [15:0] addr = '0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        we = 1'b0;
    logic [13:0] la = '0;
    logic [31:0] ld = '0;
    logic [31:0] d1, d3;
    logic        v1, f1, m1, v3, f3, m3;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d1;
        logic        f1;
        logic [31:0] d3;
        logic        f3;
        logic        m;
    } vec_t;
    vec_t vec [10];

    always #5 I_clk = ~I_clk;

    ceespu_imem_pipe #(.LATENCY(1)) u_l1 (
        .I_clk(I_clk), .I_rst(I_rst), .I_imemAddress(addr), .I_imemEnable(en),
        .I_imemReset(flush), .O_imemData(d1), .O_imemValid(v1), .O_imemFault(f1),
        .O_imemMisalign(m1), .I_loadWe(we), .I_loadAddr(la), .I_loadData(ld)
    );

    ceespu_imem_pipe #(.LATENCY(3), .DEPTH_LOG2(4)) u_l3 (
        .I_clk(I_clk), .I_rst(I_rst), .I_imemAddress(addr), .I_imemEnable(en),
        .I_imemReset(flush), .O_imemData(d3), .O_imemValid(v3), .O_imemFault(f3),
        .O_imemMisalign(m3), .I_loadWe(we), .I_loadAddr(la[3:0]), .I_loadData(ld)
    );

    task automatic tick;
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [13:0] idx, input logic [31:0] data);
        la = idx;
        ld = data;
        we = 1'b1;
        tick;
        we = 1'b0;
    endtask

    initial begin
        vec[0] = '{16'h0000, 32'hC0DE0001, 1'b0, 32'hC0DE0001, 1'b0, 1'b0};
        vec[1] = '{16'h0004, 32'hC0DE0002, 1'b0, 32'hC0DE0002, 1'b0, 1'b0};
        vec[2] = '{16'h0008, 32'hC0DE0003, 1'b0, 32'hC0DE0003, 1'b0, 1'b0};
        vec[3] = '{16'h0013, 32'hC0DE0005, 1'b0, 32'hC0DE0005, 1'b0, 1'b1};
        vec[4] = '{16'h0022, 32'hC0DE0009, 1'b0, 32'hC0DE0009, 1'b0, 1'b1};
        vec[5] = '{16'h0030, 32'hC0DE000D, 1'b0, 32'hC0DE000D, 1'b0, 1'b0};
        vec[6] = '{16'h0038, 32'hC0DE000F, 1'b0, 32'hC0DE000F, 1'b0, 1'b0};
        vec[7] = '{16'h003C, 32'hC0DE0010, 1'b0, 32'hC0DE0000, 1'b1, 1'b0};
        vec[8] = '{16'hFFFC, 32'hC0DE0000, 1'b1, 32'hC0DE0000, 1'b1, 1'b0};
        vec[9] = '{16'hFFFF, 32'hC0DE0000, 1'b1, 32'hC0DE0000, 1'b1, 1'b1};

        repeat (2) tick;
        chk("rst l1 data", d1, 0);
        chk("rst l1 valid", v1, 0);
        chk("rst l3 data", d3, 0);
        chk("rst l3 valid", v3, 0);
        chk("rst l3 flags", {f3, m3}, 0);
        I_rst = 1'b0;

        // index 16 first: in the 16-word instance it aliases to 0, which is then rewritten
        load(14'd16, 32'hC0DE0010);
        for (int i = 0; i < 16; i++) load(14'(i), 32'hC0DE0000 + i);

        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) addr = vec[i].a;
            tick;
            if (i < 10) begin
                chk($sformatf("v%0d l1 data", i), d1, vec[i].d1);
                chk($sformatf("v%0d l1 valid", i), v1, 1);
                chk($sformatf("v%0d l1 fault", i), f1, vec[i].f1);
                chk($sformatf("v%0d l1 misalign", i), m1, vec[i].m);
            end
            if (i >= 2) begin
                chk($sformatf("v%0d l3 data", i - 2), d3, vec[i-2].d3);
                chk($sformatf("v%0d l3 valid", i - 2), v3, 1);
                chk($sformatf("v%0d l3 fault", i - 2), f3, vec[i-2].f3);
                chk($sformatf("v%0d l3 misalign", i - 2), m3, vec[i-2].m);
            end
        end
        en = 1'b0;

        // single-cycle fetch of a freshly loaded word
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush l1 valid", v1, 0);
        load(14'd5, 32'hDEADBEEF);
        addr = 16'h0010;
        en = 1'b1;
        tick;
        en = 1'b0;
        chk("lat1 data", d1, 32'hDEADBEEF);
        chk("lat1 valid", v1, 1);
        chk("lat1 flags", {f1, m1}, 0);
        tick;
        chk("lat1 stall hold", d1, 32'hDEADBEEF);

        // back-to-back fetches with a two-cycle stall
        flush = 1'b1;
        tick;
        flush = 1'b0;
        en = 1'b1;
        addr = 16'h0000; tick;
        addr = 16'h0004; tick;
        addr = 16'h0008; tick;
        chk("b2b edge3", d3, 32'hC0DE0001);
        chk("b2b edge3 valid", v3, 1);
        addr = 16'h000C; tick;
        chk("b2b edge4", d3, 32'hC0DE0002);
        en = 1'b0;
        tick;
        chk("stall1", d3, 32'hC0DE0002);
        tick;
        chk("stall2", d3, 32'hC0DE0002);
        chk("stall2 valid", v3, 1);
        en = 1'b1;
        tick;
        chk("resume", d3, 32'hC0DE0003);

        // flush with two fetches in flight
        addr = 16'h0010; tick;
        addr = 16'h0014; tick;
        flush = 1'b1;
        addr = 16'h0020;
        tick;
        flush = 1'b0;
        chk("flush data", d3, 0);
        chk("flush valid", v3, 0);
        chk("flush flags", {f3, m3}, 0);
        addr = 16'h0008; tick;
        chk("post flush e1 valid", v3, 0);
        addr = 16'h000C; tick;
        chk("post flush e2 valid", v3, 0);
        addr = 16'h0010; tick;
        chk("post flush e3 data", d3, 32'hC0DE0003);
        chk("post flush e3 valid", v3, 1);

        // asynchronous reset with the pipeline full
        addr = 16'h0013; tick;
        addr = 16'h003C; tick;
        addr = 16'h0004; tick;
        chk("pre rst valid", v3, 1);
        chk("pre rst misalign", m3, 1);
        #2 I_rst = 1'b1;
        #1;
        chk("async rst l3 data", d3, 0);
        chk("async rst l3 valid", v3, 0);
        chk("async rst l3 flags", {f3, m3}, 0);
        chk("async rst l1 data", d1, 0);
        chk("async rst l1 valid", v1, 0);
        #1 I_rst = 1'b0;
        addr = 16'h0000;
        tick;
        chk("after rst e1 valid", v3, 0);
        tick;
        chk("after rst e2 valid", v3, 0);
        tick;
        chk("after rst e3 valid", v3, 1);
        chk("after rst mem kept l3", d3, 32'hC0DE0001);
        chk("after rst mem kept l1", d1, 32'hC0DE0001);
        en = 1'b0;

        // load and read of the same index on one edge returns the old word
        load(14'd7, 32'h0);
        la = 14'd7;
        ld = 32'h12345678;
        we = 1'b1;
        addr = 16'h0018;
        en = 1'b1;
        tick;
        we = 1'b0;
        chk("rw same edge old", d1, 32'h0);
        chk("rw same edge valid", v1, 1);
        tick;
        chk("rw next read new", d1, 32'h12345678);
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
